load_align_unit: RTL and testbench
==================================

Name: load_align_unit

Overview:
- Sequential successor to the combinational load-data masker in the memory stage.
- Accepts one load request (address, size, sign mode) and issues aligned N-bit reads to data memory.
- Splits any access crossing an N/8-byte boundary into two reads, merges and shifts the bytes, then sign- or zero-extends.
- Returns the result over a valid/ready handshake; sits between the memory-stage pipeline register and the data memory port.

Parameters:
- N, 64, data/word width in bits; power of two, 32 or 64.
- ADDR_W, 64, address width in bits.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- reqValid  input  1  load request present.
- reqReady  output  1  unit can accept a request.
- reqAddr  input  ADDR_W  byte address.
- reqWidth  input  2  log2 of byte count: 0=B, 1=H, 2=W, 3=D.
- reqSigned  input  1  1 = sign-extend, 0 = zero-extend.
- memReqValid  output  1  memory read request.
- memReqReady  input  1  memory accepts request.
- memAddr  output  ADDR_W  word-aligned read address (low log2(N/8) bits zero).
- memRValid  input  1  read data valid.
- memRData  input  N  read data word.
- rspValid  output  1  result available.
- rspReady  input  1  consumer takes result.
- rspData  output  N  extended load result.
- rspSplit  output  1  result needed two memory reads.
- rspErr  output  1  illegal width (reqWidth=3 with N=32); rspData=0.

Behaviour:
- Definitions: B = N/8; off = reqAddr[log2(B)-1:0]; size = 1<<reqWidth; cross = (off + size > B).
- Reset (async, rst_n=0): state IDLE.
  - reqReady=1 after release; memReqValid=0; rspValid=0; rspData=0; rspSplit=0; rspErr=0; memAddr=0; internal data registers 0.
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE: reqReady=1. On reqValid, latch addr/width/signed/off/cross.
  - Legal width: go to REQ0.
  - Illegal width: go to RESP with rspErr=1 and no memory access.
- REQ0: memReqValid=1, memAddr = reqAddr with offset bits cleared. Hold until memReqReady, then go to WAIT0. Address is stable while waiting.
- WAIT0: on memRValid, capture lo = memRData. Then go to REQ1 if cross, else to RESP.
- REQ1: memReqValid=1, memAddr = previous memAddr + B, modulo 2^ADDR_W (wraps at top of address space). On memReqReady, go to WAIT1.
- WAIT1: on memRValid, capture hi, then go to RESP.
- RESP: rspValid=1; rspData and rspSplit (=cross) are registered and stable until rspReady.
  - On rspReady, go to IDLE; reqReady is asserted the following cycle (no same-cycle back-to-back).
- Data formation:
  - merged = {hi, lo} >> (off*8), 2N bits; hi = 0 when not crossing.
  - Take the low size*8 bits and extend to N with bit (size*8-1) if reqSigned, else zeros.
  - Width = N/8 bytes: no extension.
- memRValid outside WAIT0/WAIT1 is ignored. reqValid outside IDLE is ignored (reqReady=0).
- Latency, no stalls (memReqReady=1, read data the cycle after the request):
  - Aligned: accept at t, request at t+1, data at t+2, rspValid at t+3.
  - Split: rspValid at t+5.
- Exactly one memory request outstanding at a time.
- Reset mid-operation aborts the transaction immediately. The memory side is reset by the same rst_n, so no stale response returns.

Test Plan:
- Reset: hold rst_n=0 while reqValid=1 -> all outputs 0; after release reqReady=1 and memReqValid stays 0.
- Aligned signed byte: N=64, addr 0x1003, width 0, signed, memRData=0x0000_0000_8000_0000 -> one read at 0x1000, rspData=0xFFFF_FFFF_FFFF_FF80, rspSplit=0, rspValid at t+3.
- Split word, zero-extend: addr 0x2006, width 2, lo=0xAABB_0000_0000_0000, hi=0x0000_0000_0000_CCDD -> reads at 0x2000 then 0x2008, rspData=0x0000_0000_CCDD_AABB, rspSplit=1.
- Backpressure: memReqReady low 3 cycles in REQ0 and rspReady low 4 cycles in RESP -> memAddr and rspData stable throughout; reqReady stays 0 until the cycle after rspReady.
- Wrap and error: split doubleword at 0xFFFF_FFFF_FFFF_FFFC -> second memAddr=0x0; with N=32, width 3 -> rspErr=1, rspData=0, no memReqValid.
- Reset mid-split: deassert rst_n in WAIT1 -> immediate IDLE, rspValid never asserted; a fresh aligned load afterwards completes correctly.

Source files
------------

// File: rtl/load_align_unit.sv
// ---------------------------------------------------------------------------
// load_align_unit
//
// Sequential load aligner for the memory stage. It accepts one load request
// (byte address, log2 size, sign mode) and issues word-aligned N-bit reads to
// data memory. If the access crosses an N/8-byte boundary, it issues two reads.
// The unit merges the two words, shifts the addressed bytes down to bit 0,
// sign- or zero-extends them, and returns the result over a valid/ready
// handshake. Only one memory request is outstanding at a time.
//
// Parameters
//   N       data word width in bits (32 or 64)
//   ADDR_W  byte address width in bits
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   reqValid/reqReady       load request handshake
//   reqAddr                 byte address of the load
//   reqWidth                log2 of byte count (0=B, 1=H, 2=W, 3=D)
//   reqSigned               1 = sign-extend, 0 = zero-extend
//   memReqValid/memReqReady memory read request handshake
//   memAddr                 word-aligned read address
//   memRValid/memRData      read data return
//   rspValid/rspReady       result handshake
//   rspData                 extended load result
//   rspSplit                result needed two memory reads
//   rspErr                  width larger than the data word; rspData is 0
// ---------------------------------------------------------------------------
module load_align_unit #(
    parameter int N      = 64,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic [ADDR_W-1:0] reqAddr,
    input  logic [1:0]        reqWidth,
    input  logic              reqSigned,
    output logic              memReqValid,
    input  logic              memReqReady,
    output logic [ADDR_W-1:0] memAddr,
    input  logic              memRValid,
    input  logic [N-1:0]      memRData,
    output logic              rspValid,
    input  logic              rspReady,
    output logic [N-1:0]      rspData,
    output logic              rspSplit,
    output logic              rspErr
);

    localparam int B     = N / 8;
    localparam int OFF_W = $clog2(B);
    localparam logic [ADDR_W-1:0] ADDR_MASK = {ADDR_W{1'b1}} << OFF_W;

    typedef enum logic [2:0] {
        IDLE,
        REQ0,
        WAIT0,
        REQ1,
        WAIT1,
        RESP
    } state_t;

    state_t state, state_nxt;

    // Request attributes latched at acceptance
    logic [OFF_W-1:0]  off_q;
    logic [1:0]        width_q;
    logic              signed_q;
    logic              cross_q;

    // Datapath registers
    logic [ADDR_W-1:0] mem_addr_q;
    logic [N-1:0]      lo_q;
    logic [N-1:0]      rsp_data_q;
    logic              rsp_split_q;
    logic              rsp_err_q;

    logic [OFF_W-1:0]  req_off;
    logic              req_cross;
    logic              req_illegal;
    logic              accept;
    logic [N-1:0]      merged_word;

    // Shifts {hi,lo} down by the byte offset, keeps the low (8<<width) bits,
    // and fills the upper bits with the top kept bit (signed) or zeros.
    function automatic logic [N-1:0] align_extend(
        input logic [N-1:0]     hi,
        input logic [N-1:0]     lo,
        input logic [OFF_W-1:0] off,
        input logic [1:0]       width,
        input logic             sgn
    );
        logic [2*N-1:0] merged;
        logic [N-1:0]   res;
        logic           top;
        int             nbits;
        merged = {hi, lo} >> {off, 3'b000};
        res    = merged[N-1:0];
        nbits  = 8 << width;
        case (width)
            2'd0:    top = merged[7];
            2'd1:    top = merged[15];
            2'd2:    top = merged[31];
            default: top = merged[N-1];
        endcase
        if (nbits < N) begin
            for (int i = 0; i < N; i++) begin
                if (i >= nbits) res[i] = sgn & top;
            end
        end
        return res;
    endfunction

    // Request decode
    always_comb begin
        int req_bytes;
        req_bytes   = 1 << reqWidth;
        req_off     = reqAddr[OFF_W-1:0];
        req_illegal = (req_bytes > B);
        req_cross   = !req_illegal && ((int'(req_off) + req_bytes) > B);
    end

    assign accept = (state == IDLE) && reqValid;

    // A non-crossing access finishes in WAIT0 with hi = 0 and lo = the read
    // word. A crossing access finishes in WAIT1 with the stored lo word.
    assign merged_word = align_extend(cross_q ? memRData : '0,
                                      cross_q ? lo_q     : memRData,
                                      off_q, width_q, signed_q);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_nxt   = state;
        reqReady    = 1'b0;
        memReqValid = 1'b0;
        rspValid    = 1'b0;
        case (state)
            IDLE: begin
                // Gated by rst_n so that reqReady stays low while reset is held
                reqReady = rst_n;
                if (reqValid) state_nxt = req_illegal ? RESP : REQ0;
            end
            REQ0: begin
                memReqValid = 1'b1;
                if (memReqReady) state_nxt = WAIT0;
            end
            WAIT0: begin
                if (memRValid) state_nxt = cross_q ? REQ1 : RESP;
            end
            REQ1: begin
                memReqValid = 1'b1;
                if (memReqReady) state_nxt = WAIT1;
            end
            WAIT1: begin
                if (memRValid) state_nxt = RESP;
            end
            RESP: begin
                rspValid = 1'b1;
                if (rspReady) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, read capture and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_q       <= '0;
            width_q     <= '0;
            signed_q    <= 1'b0;
            cross_q     <= 1'b0;
            mem_addr_q  <= '0;
            lo_q        <= '0;
            rsp_data_q  <= '0;
            rsp_split_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        off_q    <= req_off;
                        width_q  <= reqWidth;
                        signed_q <= reqSigned;
                        cross_q  <= req_cross;
                        if (req_illegal) begin
                            rsp_data_q  <= '0;
                            rsp_split_q <= 1'b0;
                            rsp_err_q   <= 1'b1;
                        end else begin
                            mem_addr_q <= reqAddr & ADDR_MASK;
                        end
                    end
                end
                WAIT0: begin
                    if (memRValid) begin
                        lo_q <= memRData;
                        if (cross_q) begin
                            // Next word; wraps naturally at the top of memory
                            mem_addr_q <= mem_addr_q + ADDR_W'(B);
                        end else begin
                            rsp_data_q  <= merged_word;
                            rsp_split_q <= 1'b0;
                            rsp_err_q   <= 1'b0;
                        end
                    end
                end
                WAIT1: begin
                    if (memRValid) begin
                        rsp_data_q  <= merged_word;
                        rsp_split_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                    end
                end
                RESP: begin
                    if (rspReady) begin
                        rsp_data_q  <= '0;
                        rsp_split_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign memAddr  = mem_addr_q;
    assign rspData  = rsp_data_q;
    assign rspSplit = rsp_split_q;
    assign rspErr   = rsp_err_q;

endmodule

// File: tb/tb_load_align_unit.sv
// ---------------------------------------------------------------------------
// tb_load_align_unit
//
// Directed bench for load_align_unit. It instantiates a 64-bit unit for the
// main load cases and a 32-bit unit for the illegal-width case. Inputs change
// and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_load_align_unit;

    logic        clk;
    logic        rst_n;

    // 64-bit unit
    logic        reqValid, reqReady, reqSigned;
    logic [63:0] reqAddr;
    logic [1:0]  reqWidth;
    logic        memReqValid, memReqReady, memRValid;
    logic [63:0] memAddr, memRData;
    logic        rspValid, rspReady, rspSplit, rspErr;
    logic [63:0] rspData;

    // 32-bit unit
    logic        reqValid32, reqReady32, reqSigned32;
    logic [31:0] reqAddr32;
    logic [1:0]  reqWidth32;
    logic        memReqValid32, memReqReady32, memRValid32;
    logic [31:0] memAddr32, memRData32;
    logic        rspValid32, rspReady32, rspSplit32, rspErr32;
    logic [31:0] rspData32;

    int checks;
    int errors;

    load_align_unit #(.N(64), .ADDR_W(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .reqValid(reqValid), .reqReady(reqReady), .reqAddr(reqAddr),
        .reqWidth(reqWidth), .reqSigned(reqSigned),
        .memReqValid(memReqValid), .memReqReady(memReqReady), .memAddr(memAddr),
        .memRValid(memRValid), .memRData(memRData),
        .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData),
        .rspSplit(rspSplit), .rspErr(rspErr)
    );

    load_align_unit #(.N(32), .ADDR_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .reqValid(reqValid32), .reqReady(reqReady32), .reqAddr(reqAddr32),
        .reqWidth(reqWidth32), .reqSigned(reqSigned32),
        .memReqValid(memReqValid32), .memReqReady(memReqReady32), .memAddr(memAddr32),
        .memRValid(memRValid32), .memRData(memRData32),
        .rspValid(rspValid32), .rspReady(rspReady32), .rspData(rspData32),
        .rspSplit(rspSplit32), .rspErr(rspErr32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request on the 64-bit unit for one cycle (called at negedge)
    task automatic issue(input string tag, input logic [63:0] a, input logic [1:0] w, input logic s);
        chk({tag, "_req_ready"}, reqReady, 1);
        reqValid = 1'b1; reqAddr = a; reqWidth = w; reqSigned = s;
        @(negedge clk);
        reqValid = 1'b0;
    endtask

    // Serve one read: the request must be up now, data returns the next cycle
    task automatic mem_read(input string tag, input logic [63:0] exp_addr, input logic [63:0] data);
        chk({tag, "_mem_valid"}, memReqValid, 1);
        chk({tag, "_mem_addr"}, memAddr, exp_addr);
        chk({tag, "_req_ready_busy"}, reqReady, 0);
        @(negedge clk);
        chk({tag, "_mem_idle"}, memReqValid, 0);
        chk({tag, "_no_early_rsp"}, rspValid, 0);
        memRValid = 1'b1; memRData = data;
        @(negedge clk);
        memRValid = 1'b0; memRData = 64'hDEAD_BEEF_DEAD_BEEF;
    endtask

    // Check the response (rspReady held high) and the return to idle
    task automatic check_rsp(input string tag, input logic [63:0] data, input logic split);
        chk({tag, "_rsp_valid"}, rspValid, 1);
        chk({tag, "_rsp_data"}, rspData, data);
        chk({tag, "_rsp_split"}, rspSplit, split);
        chk({tag, "_rsp_err"}, rspErr, 0);
        @(negedge clk);
        chk({tag, "_rsp_done"}, rspValid, 0);
        chk({tag, "_ready_again"}, reqReady, 1);
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0;
        reqValid = 1'b1; reqAddr = 64'h1234; reqWidth = 2'd0; reqSigned = 1'b0;
        memReqReady = 1'b1; memRValid = 1'b0; memRData = '0; rspReady = 1'b1;
        reqValid32 = 1'b0; reqAddr32 = '0; reqWidth32 = 2'd0; reqSigned32 = 1'b0;
        memReqReady32 = 1'b1; memRValid32 = 1'b0; memRData32 = '0; rspReady32 = 1'b1;

        // Reset held with a request pending: everything quiet
        repeat (3) @(negedge clk);
        chk("rst_req_ready", reqReady, 0);
        chk("rst_mem_valid", memReqValid, 0);
        chk("rst_mem_addr", memAddr, 0);
        chk("rst_rsp_valid", rspValid, 0);
        chk("rst_rsp_data", rspData, 0);
        chk("rst_rsp_split", rspSplit, 0);
        chk("rst_rsp_err", rspErr, 0);
        reqValid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", reqReady, 1);
        chk("post_rst_mem_valid", memReqValid, 0);
        @(negedge clk);
        chk("post_rst_mem_valid2", memReqValid, 0);

        // Aligned signed byte at 0x1003: 0x80 -> sign-extended
        issue("sb", 64'h1003, 2'd0, 1'b1);
        mem_read("sb", 64'h1000, 64'h0000_0000_8000_0000);
        check_rsp("sb", 64'hFFFF_FFFF_FFFF_FF80, 1'b0);

        // Aligned unsigned byte at 0x1007
        issue("ub", 64'h1007, 2'd0, 1'b0);
        mem_read("ub", 64'h1000, 64'hF011_2233_4455_6677);
        check_rsp("ub", 64'h0000_0000_0000_00F0, 1'b0);

        // Split word zero-extend at 0x2006
        issue("sw", 64'h2006, 2'd2, 1'b0);
        mem_read("sw_lo", 64'h2000, 64'hAABB_0000_0000_0000);
        mem_read("sw_hi", 64'h2008, 64'h0000_0000_0000_CCDD);
        check_rsp("sw", 64'h0000_0000_CCDD_AABB, 1'b1);

        // Split signed halfword at offset 7
        issue("sh", 64'h4007, 2'd1, 1'b1);
        mem_read("sh_lo", 64'h4000, 64'hAB00_0000_0000_0000);
        mem_read("sh_hi", 64'h4008, 64'h0000_0000_0000_00CD);
        check_rsp("sh", 64'hFFFF_FFFF_FFFF_CDAB, 1'b1);

        // Backpressure on the memory request and on the response
        memReqReady = 1'b0; rspReady = 1'b0;
        issue("bp", 64'h3004, 2'd1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("bp_mem_valid", memReqValid, 1);
            chk("bp_mem_addr", memAddr, 64'h3000);
            chk("bp_req_ready", reqReady, 0);
            if (i < 3) @(negedge clk);
        end
        memReqReady = 1'b1;
        @(negedge clk);
        chk("bp_mem_idle", memReqValid, 0);
        memRValid = 1'b1; memRData = 64'h0000_9234_0000_0000;
        @(negedge clk);
        memRValid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", rspValid, 1);
            chk("bp_rsp_data", rspData, 64'hFFFF_FFFF_FFFF_9234);
            chk("bp_req_ready_hold", reqReady, 0);
            if (i < 4) @(negedge clk);
        end
        rspReady = 1'b1;
        @(negedge clk);
        chk("bp_rsp_done", rspValid, 0);
        chk("bp_req_ready_back", reqReady, 1);

        // Split doubleword wrapping past the top of the address space
        issue("wr", 64'hFFFF_FFFF_FFFF_FFFC, 2'd3, 1'b1);
        mem_read("wr_lo", 64'hFFFF_FFFF_FFFF_FFF8, 64'h8765_4321_0000_0000);
        mem_read("wr_hi", 64'h0000_0000_0000_0000, 64'h0000_0000_FEDC_BA98);
        check_rsp("wr", 64'hFEDC_BA98_8765_4321, 1'b1);

        // Illegal doubleword on the 32-bit unit
        chk("e32_req_ready", reqReady32, 1);
        reqValid32 = 1'b1; reqAddr32 = 32'h0000_0100; reqWidth32 = 2'd3; reqSigned32 = 1'b1;
        @(negedge clk);
        reqValid32 = 1'b0;
        chk("e32_rsp_valid", rspValid32, 1);
        chk("e32_rsp_err", rspErr32, 1);
        chk("e32_rsp_data", rspData32, 0);
        chk("e32_rsp_split", rspSplit32, 0);
        chk("e32_mem_valid", memReqValid32, 0);
        @(negedge clk);
        chk("e32_rsp_done", rspValid32, 0);
        chk("e32_mem_valid2", memReqValid32, 0);
        chk("e32_req_ready2", reqReady32, 1);

        // Reset while waiting for the second read of a split access
        issue("rm", 64'h5006, 2'd2, 1'b0);
        mem_read("rm_lo", 64'h5000, 64'h1111_2222_3333_4444);
        chk("rm_mem_valid", memReqValid, 1);
        chk("rm_mem_addr", memAddr, 64'h5008);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rm_rst_mem_valid", memReqValid, 0);
        chk("rm_rst_rsp_valid", rspValid, 0);
        chk("rm_rst_mem_addr", memAddr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        memRValid = 1'b1; memRData = 64'h5555_6666_7777_8888;
        @(negedge clk);
        memRValid = 1'b0;
        chk("rm_after_rsp_valid", rspValid, 0);
        chk("rm_after_rsp_data", rspData, 0);
        chk("rm_after_mem_valid", memReqValid, 0);

        // A fresh aligned load completes normally
        issue("fr", 64'h6000, 2'd3, 1'b0);
        mem_read("fr", 64'h6000, 64'h0123_4567_89AB_CDEF);
        check_rsp("fr", 64'h0123_4567_89AB_CDEF, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
